// File: rtl/rv64m_muldiv_unit.sv
// RV64M multiply/divide unit: single-cycle multiplies and a 64-iteration
// restoring radix-2 divider. The divider stalls the pipeline while it is busy.
module rv64m_muldiv_unit #(
  parameter logic [5:0] OP_BASE = 6'd32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [5:0]  alu_operation_i,
  output logic [63:0] alu_result_oa,
  output logic        stall_o
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(XLEN);

  localparam logic [3:0] OFF_MUL    = 4'd0;
  localparam logic [3:0] OFF_MULH   = 4'd1;
  localparam logic [3:0] OFF_MULHSU = 4'd2;
  localparam logic [3:0] OFF_MULHU  = 4'd3;
  localparam logic [3:0] OFF_MULW   = 4'd4;
  localparam logic [3:0] OFF_DIV    = 4'd5;
  localparam logic [3:0] OFF_REM    = 4'd7;
  localparam logic [3:0] OFF_REMU   = 4'd8;
  localparam logic [3:0] OFF_DIVW   = 4'd9;
  localparam logic [3:0] OFF_REMW   = 4'd11;
  localparam logic [3:0] OFF_REMUW  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_count;
  logic [XLEN-1:0]       r_quot, r_rem, r_divisor;
  logic                  r_q_neg, r_r_neg;

  // Operation decode; the 7-bit difference catches ops below OP_BASE via bit 6.
  logic [6:0] w_off_full;
  logic [3:0] w_off;
  logic       w_valid, w_is_mul, w_is_div, w_word, w_sgn, w_rem;

  assign w_off_full = 7'(alu_operation_i) - 7'(OP_BASE);
  assign w_valid    = !w_off_full[6] && (w_off_full[5:0] <= 6'd12);
  assign w_off      = w_off_full[3:0];
  assign w_is_mul   = w_valid && (w_off <= OFF_MULW);
  assign w_is_div   = w_valid && (w_off >= OFF_DIV);
  assign w_word     = (w_off >= OFF_DIVW);
  assign w_sgn      = (w_off == OFF_DIV) || (w_off == OFF_REM) ||
                      (w_off == OFF_DIVW) || (w_off == OFF_REMW);
  assign w_rem      = (w_off == OFF_REM) || (w_off == OFF_REMU) ||
                      (w_off == OFF_REMW) || (w_off == OFF_REMUW);

  // One 65x65 signed multiplier covers all signedness combinations.
  logic               w_ma_sgn, w_mb_sgn;
  logic signed [64:0] w_ma, w_mb;
  logic signed [127:0] w_prod;
  logic [XLEN-1:0]    w_mul_res;

  assign w_ma_sgn = (w_off == OFF_MULH) || (w_off == OFF_MULHSU);
  assign w_mb_sgn = (w_off == OFF_MULH);
  assign w_ma     = {w_ma_sgn & a_i[63], a_i};
  assign w_mb     = {w_mb_sgn & b_i[63], b_i};
  assign w_prod   = 128'(w_ma) * 128'(w_mb);

  always_comb begin
    w_mul_res = '0;
    if (w_is_mul) begin
      case (w_off)
        OFF_MUL:  w_mul_res = w_prod[63:0];
        OFF_MULW: w_mul_res = sext32(w_prod[31:0]);
        default:  w_mul_res = w_prod[127:64];
      endcase
    end
  end

  // Divide operands at op width, extended to 64 bits.
  logic [XLEN-1:0] w_dvd, w_dvs, w_dvd_abs, w_dvs_abs, w_ovf_min;
  logic [XLEN-1:0] w_spec_raw, w_spec_res;
  logic            w_dvd_neg, w_dvs_neg, w_div_zero, w_ovf, w_special;

  assign w_dvd      = w_word ? (w_sgn ? sext32(a_i[31:0]) : {32'b0, a_i[31:0]}) : a_i;
  assign w_dvs      = w_word ? (w_sgn ? sext32(b_i[31:0]) : {32'b0, b_i[31:0]}) : b_i;
  assign w_dvd_neg  = w_sgn & w_dvd[XLEN-1];
  assign w_dvs_neg  = w_sgn & w_dvs[XLEN-1];
  assign w_dvd_abs  = w_dvd_neg ? -w_dvd : w_dvd;
  assign w_dvs_abs  = w_dvs_neg ? -w_dvs : w_dvs;
  assign w_ovf_min  = w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign w_div_zero = (w_dvs == '0);
  assign w_ovf      = w_sgn && (w_dvd == w_ovf_min) && (w_dvs == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_spec_raw = w_rem ? (w_div_zero ? w_dvd : '0) : (w_div_zero ? '1 : w_dvd);
  assign w_spec_res = w_word ? sext32(w_spec_raw[31:0]) : w_spec_raw;

  // Restoring step: the shifted remainder needs one extra bit.
  logic [XLEN:0] w_rem_sh, w_diff;
  logic          w_ge;

  assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};
  assign w_ge     = !w_diff[XLEN];

  logic [XLEN-1:0] w_q_fix, w_r_fix, w_done_raw, w_done_res;

  assign w_q_fix    = r_q_neg ? -r_quot : r_quot;
  assign w_r_fix    = r_r_neg ? -r_rem : r_rem;
  assign w_done_raw = w_rem ? w_r_fix : w_q_fix;
  assign w_done_res = w_word ? sext32(w_done_raw[31:0]) : w_done_raw;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, stall and result mux.
  always_comb begin
    w_state_nxt   = r_state;
    stall_o       = 1'b0;
    alu_result_oa = '0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            if (w_special) begin
              alu_result_oa = w_spec_res;
            end else begin
              stall_o     = 1'b1;
              w_state_nxt = S_BUSY;
            end
          end else begin
            alu_result_oa = w_mul_res;
          end
        end
        S_BUSY: begin
          if (w_is_div) begin
            stall_o = 1'b1;
            if (r_count == CNT_W'(1)) w_state_nxt = S_DONE;
          end else begin
            alu_result_oa = w_mul_res;
            w_state_nxt   = S_IDLE;
          end
        end
        S_DONE: begin
          w_state_nxt   = S_IDLE;
          alu_result_oa = w_is_div ? w_done_res : w_mul_res;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count   <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
    end else if (r_state == S_IDLE && w_state_nxt == S_BUSY) begin
      r_count   <= ITERS;
      r_quot    <= w_dvd_abs;
      r_rem     <= '0;
      r_divisor <= w_dvs_abs;
      r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg   <= w_dvd_neg;
    end else if (r_state == S_BUSY) begin
      r_count <= r_count - CNT_W'(1);
      r_quot  <= {r_quot[XLEN-2:0], w_ge};
      r_rem   <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_rv64m_muldiv_unit.sv
// Directed bench for rv64m_muldiv_unit: multiplies, divides, special cases,
// word ops, reset and abort during a divide.
module tb_rv64m_muldiv_unit;

  localparam logic [5:0] OP_MUL    = 6'd32;
  localparam logic [5:0] OP_MULH   = 6'd33;
  localparam logic [5:0] OP_MULHSU = 6'd34;
  localparam logic [5:0] OP_MULHU  = 6'd35;
  localparam logic [5:0] OP_MULW   = 6'd36;
  localparam logic [5:0] OP_DIV    = 6'd37;
  localparam logic [5:0] OP_DIVU   = 6'd38;
  localparam logic [5:0] OP_REM    = 6'd39;
  localparam logic [5:0] OP_REMU   = 6'd40;
  localparam logic [5:0] OP_DIVW   = 6'd41;
  localparam logic [5:0] OP_DIVUW  = 6'd42;
  localparam logic [5:0] OP_REMW   = 6'd43;
  localparam logic [5:0] OP_REMUW  = 6'd44;
  localparam int STALL_LIMIT = 200;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] a_i, b_i;
  logic [5:0]  alu_operation_i;
  logic [63:0] alu_result_oa;
  logic        stall_o;

  int errors = 0;
  int checks = 0;

  rv64m_muldiv_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .alu_operation_i (alu_operation_i),
    .alu_result_oa   (alu_result_oa),
    .stall_o         (stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive just after a rising edge and sample at the following falling edge.
  task automatic apply(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic stl);
    @(posedge clk_i); #1;
    alu_operation_i = op; a_i = a; b_i = b;
    @(negedge clk_i);
    res = alu_result_oa; stl = stall_o;
  endtask

  // Issue a divide and count stalled cycles until the result appears (bounded).
  task automatic run_div(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int stalls, output logic [63:0] res);
    logic stl;
    apply(op, a, b, res, stl);
    stalls = 0;
    while (stall_o && stalls < STALL_LIMIT) begin
      stalls++;
      @(negedge clk_i);
    end
    res = alu_result_oa;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; alu_operation_i = OP_MUL; a_i = 64'd3; b_i = 64'd4;
    repeat (2) @(negedge clk_i);
    checks++;
    if (alu_result_oa !== 64'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: result=%h stall=%b, required 0/0", alu_result_oa, stall_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; alu_operation_i = 6'd0;
  endtask

  task automatic test_mul;
    logic [5:0]  ops  [4] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    logic [63:0] exps [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
    logic [63:0] res;
    logic        stl;
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, res, stl);
      checks++;
      if (res !== exps[i] || stl !== 1'b0) begin
        errors++;
        $display("FAIL mul_op%0d: result=%h stall=%b, required %h/0", ops[i], res, stl, exps[i]);
      end
    end
  endtask

  task automatic test_mulw;
    logic [63:0] res;
    logic        stl;
    apply(OP_MULW, 64'h0000_0000_8000_0000, 64'h2, res, stl);
    checks++;
    if (res !== 64'h0 || stl !== 1'b0) begin
      errors++;
      $display("FAIL mulw_wrap: result=%h stall=%b, required 0/0", res, stl);
    end
    apply(OP_MULW, 64'hABCD_0000_4000_0000, 64'h1234_0000_0000_0002, res, stl);
    checks++;
    if (res !== 64'hFFFF_FFFF_8000_0000 || stl !== 1'b0) begin
      errors++;
      $display("FAIL mulw_sext: result=%h stall=%b, required ffffffff80000000/0", res, stl);
    end
  endtask

  task automatic test_unknown;
    logic [63:0] res;
    logic        stl;
    apply(6'd0, 64'd3, 64'd4, res, stl);
    checks++;
    if (res !== 64'h0 || stl !== 1'b0) begin
      errors++;
      $display("FAIL unknown_low: result=%h stall=%b, required 0/0", res, stl);
    end
    apply(6'd45, 64'd100, 64'd0, res, stl);
    checks++;
    if (res !== 64'h0 || stl !== 1'b0) begin
      errors++;
      $display("FAIL unknown_high: result=%h stall=%b, required 0/0", res, stl);
    end
  endtask

  task automatic test_div;
    logic [5:0]  ops  [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [63:0] as   [6] = '{-64'sd7, -64'sd7, 64'd100, 64'd100, -64'sd100, -64'sd100};
    logic [63:0] bs   [6] = '{64'd2, 64'd2, 64'd7, 64'd7, -64'sd7, -64'sd7};
    logic [63:0] exps [6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2,
                              64'd14, 64'hFFFF_FFFF_FFFF_FFFE};
    int          stalls;
    logic [63:0] res;
    for (int i = 0; i < 6; i++) begin
      run_div(ops[i], as[i], bs[i], stalls, res);
      checks++;
      if (stalls != 65 || res !== exps[i]) begin
        errors++;
        $display("FAIL div_case%0d: stalls=%0d result=%h, required 65/%h", i, stalls, res, exps[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [5:0]  ops  [5] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVW};
    logic [63:0] as   [5] = '{64'd9, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'h5A5A_5A5A_8000_0000};
    logic [63:0] bs   [5] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0000_0001_FFFF_FFFF};
    logic [63:0] exps [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0,
                              64'hFFFF_FFFF_8000_0000};
    logic [63:0] res;
    logic        stl;
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], as[i], bs[i], res, stl);
      checks++;
      if (res !== exps[i] || stl !== 1'b0) begin
        errors++;
        $display("FAIL special_case%0d: result=%h stall=%b, required %h/0", i, res, stl, exps[i]);
      end
      // Special cases must leave the FSM idle: a park op shows no stall next cycle.
      apply(6'd0, 64'd0, 64'd0, res, stl);
      checks++;
      if (stl !== 1'b0) begin
        errors++;
        $display("FAIL special_idle%0d: stall=%b, required 0", i, stl);
      end
    end
  endtask

  task automatic test_word;
    logic [5:0]  ops  [4] = '{OP_DIVUW, OP_REMW, OP_REMW, OP_DIVW};
    logic [63:0] as   [4] = '{64'h0000_0000_FFFF_FFFF, -64'sd7, 64'hDEAD_BEEF_FFFF_FFF9,
                              64'h1234_5678_0000_0064};
    logic [63:0] bs   [4] = '{64'd1, 64'd3, 64'h1234_5678_0000_0003, 64'hABCD_0000_FFFF_FFF9};
    logic [63:0] exps [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF2};
    int          stalls;
    logic [63:0] res;
    for (int i = 0; i < 4; i++) begin
      run_div(ops[i], as[i], bs[i], stalls, res);
      checks++;
      if (stalls != 65 || res !== exps[i]) begin
        errors++;
        $display("FAIL word_case%0d: stalls=%0d result=%h, required 65/%h", i, stalls, res, exps[i]);
      end
    end
  endtask

  task automatic test_reset_mid_div;
    logic [63:0] res;
    logic        stl;
    int          stalls;
    apply(OP_DIV, -64'sd7, 64'd2, res, stl);
    repeat (19) @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (alu_result_oa !== 64'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: result=%h stall=%b, required 0/0", alu_result_oa, stall_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; alu_operation_i = OP_MUL; a_i = 64'd3; b_i = 64'd4;
    @(negedge clk_i);
    checks++;
    if (alu_result_oa !== 64'd12 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_after_reset: result=%h stall=%b, required 12/0", alu_result_oa, stall_o);
    end
    run_div(OP_DIV, -64'sd7, 64'd2, stalls, res);
    checks++;
    if (stalls != 65 || res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_after_reset: stalls=%0d result=%h, required 65/fffffffffffffffd", stalls, res);
    end
  endtask

  task automatic test_abort;
    logic [63:0] res;
    logic        stl;
    int          stalls;
    apply(OP_DIVU, 64'd100, 64'd7, res, stl);
    repeat (10) @(negedge clk_i);
    apply(OP_MUL, 64'd6, 64'd7, res, stl);
    checks++;
    if (res !== 64'd42 || stl !== 1'b0) begin
      errors++;
      $display("FAIL abort_mul: result=%h stall=%b, required 42/0", res, stl);
    end
    run_div(OP_DIVU, 64'd100, 64'd7, stalls, res);
    checks++;
    if (stalls != 65 || res !== 64'd14) begin
      errors++;
      $display("FAIL div_after_abort: stalls=%0d result=%h, required 65/14", stalls, res);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res;
    int          stalls;
    run_div(OP_DIVU, 64'd1000, 64'd9, stalls, res);
    checks++;
    if (stalls != 65 || res !== 64'd111) begin
      errors++;
      $display("FAIL b2b_first: stalls=%0d result=%h, required 65/111", stalls, res);
    end
    run_div(OP_REMU, 64'd1000, 64'd9, stalls, res);
    checks++;
    if (stalls != 65 || res !== 64'd1) begin
      errors++;
      $display("FAIL b2b_second: stalls=%0d result=%h, required 65/1", stalls, res);
    end
  endtask

  initial begin
    rst_i = 1'b1; a_i = '0; b_i = '0; alu_operation_i = '0;
    test_reset();
    test_mul();
    test_mulw();
    test_unknown();
    test_div();
    test_special();
    test_word();
    test_reset_mid_div();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
